uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter. It is the successor to the fixed-format uart_tx.
- Adds a configurable data width, an internal baud divider, optional parity, 1 or 2 stop bits, and a valid/ready handshake with a frame-done pulse.
- Sits between the host-side data path and the txd pin, alongside the existing receiver and prescaler logic.

Parameters:
DATA_W, 8, data bits per frame, legal range 5..9
DIV_W, 16, width of the runtime baud divisor

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable_tx  input  1  active-high; when 0, no new frame is accepted
baud_div  input  DIV_W  bit period minus one, in clk cycles
parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none
two_stop  input  1  1 = two stop bits, 0 = one stop bit
d_in  input  DATA_W  frame data, LSB transmitted first
tx_send  input  1  valid: request to transmit d_in
tx_ready  output  1  block can accept a frame this cycle
txd  output  1  serial line, idle high
sending  output  1  high while a frame is on the line
tx_done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset, asynchronous on rst_n low:
  - state IDLE, txd=1, sending=0, tx_done=0.
  - tx_ready is forced to 0 while rst_n is low.
  - Counters and shift register are cleared.
- Handshake:
  - tx_ready = (state==IDLE) && enable_tx.
  - A frame is accepted on the rising clk edge where tx_send && tx_ready.
  - On acceptance, d_in, baud_div, parity_mode and two_stop are latched. Later input changes do not affect the frame in flight.
- Timing:
  - At the acceptance edge, txd goes 0 (start bit) and sending goes 1. No extra latency; txd is registered.
  - Each bit lasts exactly baud_div+1 clk cycles. baud_div=0 gives one cycle per bit.
  - Frame length = (1 + DATA_W + P + S) * (baud_div+1) cycles, where P = 1 if parity is enabled and S = 1 or 2.
- FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - START: txd=0 for one bit period.
  - DATA: DATA_W bit periods, LSB first. Bit index counts 0..DATA_W-1.
  - PARITY: entered only for modes 01/10. Even: parity bit = XOR of the data bits. Odd: parity bit = inverted XOR.
  - STOP: txd=1 for 1 or 2 bit periods.
- Frame end:
  - On the last cycle of the final stop bit, the state returns to IDLE and sending falls.
  - tx_done pulses high for exactly that one cycle.
- Back-to-back frames: if tx_send is held high with enable_tx=1, the next frame is accepted on the first IDLE cycle. The idle gap is exactly 1 cycle (txd=1).
- enable_tx dropped mid-frame: the current frame completes normally and no further frame is accepted.
- tx_send while busy: ignored (tx_ready=0); the data is not queued.
- rst_n asserted mid-frame: the frame aborts immediately, txd=1, no tx_done.
- Baud counter: counts down from the latched baud_div to 0. At 0 it advances the bit and reloads. It never wraps outside a frame and holds 0 in IDLE.

Decomposition:
- Shared package uart_pkg:
  - parity_mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
  - FSM state encoding ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP.
  - Shared with the receiver successor.
- One sub-module, uart_baud_gen: a loadable down-counter with a bit_tick output and a DIV_W parameter. It is reused by the receiver.

Test Plan:
- Basic frame. Config: DATA_W=8, baud_div=3, parity none, one stop. Send d_in=0x70.
  - txd sequence per 4-cycle bit: 0 | 0,0,0,0,1,1,1,0 | 1.
  - sending high for 40 cycles; tx_done pulses once at cycle 40.
- Parity and stop bits with d_in=0x70, baud_div=3.
  - Even parity: parity bit 1.
  - Odd parity: parity bit 0.
  - two_stop=1, even parity: frame is 12 bits = 48 cycles.
- Back-to-back. Hold tx_send=1 with 0x55 then 0xAA at baud_div=0.
  - Two 10-cycle frames separated by exactly one idle cycle.
  - tx_ready high only in that gap.
- Enable and busy behaviour:
  - enable_tx=0 with tx_send=1: txd stays 1 and tx_ready=0 for 100 cycles.
  - Drop enable_tx mid-frame: the frame completes and no new start bit follows.
  - Changing d_in and baud_div mid-frame does not alter the frame.
- Reset mid-frame: assert rst_n=0 during DATA.
  - txd=1, sending=0, tx_ready=0 immediately, with no clock edge needed.
  - After release, a new 0x0F frame transmits correctly.
- DATA_W=5 instance: send 0x1F with odd parity.
  - Frame is 8 bits and the parity bit is 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes and FSM state encoding.
// Used by the transmitter and the receiver.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Mode 11 is reserved and behaves like PAR_NONE.
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable baud down-counter: bit_tick fires on the last cycle of each bit period.
// clr parks the counter at 0 so it never free-runs between frames.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt_q <= '0;
    else if (clr)       cnt_q <= '0;
    else if (load)      cnt_q <= div;
    else if (en) begin
      if (cnt_q == '0)  cnt_q <= div;
      else              cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  assign bit_tick = en && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with valid/ready intake and frame-done pulse.
// Frame config is captured at acceptance so the line is immune to later input changes.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_tx,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  input  logic [DATA_W-1:0] d_in,
  input  logic              tx_send,
  output logic              tx_ready,
  output logic              txd,
  output logic              sending,
  output logic              tx_done
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic              txd_q, txd_d;
  logic [DIV_W-1:0]  div_q;
  logic              par_en_q, par_bit_q, two_stop_q;
  logic              accept, tick, frame_end;

  assign tx_ready = rst_n && (state_q == ST_IDLE) && enable_tx;
  assign accept   = tx_send && tx_ready;
  assign sending  = (state_q != ST_IDLE);
  assign txd      = txd_q;
  assign tx_done  = frame_end;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (frame_end),
    .load     (accept),
    .en       (sending),
    .div      (accept ? baud_div : div_q),
    .bit_tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
    end
  end

  // Parity is resolved from d_in at intake; the shifter only carries data bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else if (accept) begin
      div_q      <= baud_div;
      par_en_q   <= par_enabled(parity_mode);
      par_bit_q  <= (parity_mode == PAR_ODD) ? ~(^d_in) : (^d_in);
      two_stop_q <= two_stop;
    end
  end

  // txd_d is the level for the next bit, loaded on the tick that ends the current one.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    txd_d      = txd_q;
    frame_end  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (accept) begin
          state_d    = ST_START;
          shreg_d    = d_in;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          txd_d      = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_IDX) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              txd_d   = par_bit_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            txd_d     = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            frame_end = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: expected frames are queued at send time and
// compared cycle by cycle against txd while sending is high.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          div;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        en8 = 1'b1, ts8 = 1'b0, send8 = 1'b0;
  logic [15:0] div8 = '0;
  logic [1:0]  pm8 = PAR_NONE;
  logic [7:0]  d8 = '0;
  logic        ready8, txd8, sending8, done8;

  logic        en5 = 1'b1, ts5 = 1'b0, send5 = 1'b0;
  logic [15:0] div5 = '0;
  logic [1:0]  pm5 = PAR_NONE;
  logic [4:0]  d5 = '0;
  logic        ready5, txd5, sending5, done5;

  uart_tx_cfg #(.DATA_W(8), .DIV_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .enable_tx(en8), .baud_div(div8), .parity_mode(pm8),
    .two_stop(ts8), .d_in(d8), .tx_send(send8), .tx_ready(ready8), .txd(txd8),
    .sending(sending8), .tx_done(done8));

  uart_tx_cfg #(.DATA_W(5), .DIV_W(16)) dut5 (
    .clk(clk), .rst_n(rst_n), .enable_tx(en5), .baud_div(div5), .parity_mode(pm5),
    .two_stop(ts5), .d_in(d5), .tx_send(send5), .tx_ready(ready5), .txd(txd5),
    .sending(sending5), .tx_done(done5));

  int n_chk = 0, n_err = 0;
  frame_t sb8[$];
  frame_t sb5[$];
  int npush8 = 0, ndone8 = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic frame_t mk(input logic [8:0] d, input int dw, input logic [1:0] pm,
                                input logic ts, input int div);
    frame_t f;
    logic   p;
    int     n;
    f.bits = '1;
    p = 1'b0;
    f.bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < dw; i++) begin
      f.bits[n] = d[i];
      p ^= d[i];
      n++;
    end
    if (pm == 2'b01) begin f.bits[n] = p;  n++; end
    else if (pm == 2'b10) begin f.bits[n] = ~p; n++; end
    n += ts ? 2 : 1;
    f.nbits = n;
    f.div = div;
    return f;
  endfunction

  // Per-DUT frame capture state, index 0 = dut8, 1 = dut5.
  int     cyc[2] = '{0, 0};
  logic   have[2] = '{1'b0, 1'b0};
  logic   bad[2] = '{1'b0, 1'b0};
  frame_t cur[2];

  task automatic mon(input int k, input logic snd, input logic tx, input logic dn);
    int idx;
    if (snd) begin
      if (cyc[k] == 0) begin
        bad[k] = 1'b0;
        if (k == 0 && sb8.size() > 0) begin cur[k] = sb8.pop_front(); have[k] = 1'b1; end
        else if (k == 1 && sb5.size() > 0) begin cur[k] = sb5.pop_front(); have[k] = 1'b1; end
        else begin have[k] = 1'b0; chk($sformatf("unexpected_frame%0d", k), 1, 0); end
      end
      if (have[k]) begin
        idx = cyc[k] / (cur[k].div + 1);
        if (idx >= cur[k].nbits || tx !== cur[k].bits[idx]) bad[k] = 1'b1;
      end
      cyc[k]++;
    end
    if (dn) begin
      if (k == 0) ndone8++;
      if (have[k]) begin
        chk($sformatf("frame_bits%0d", k), bad[k], 0);
        chk($sformatf("frame_len%0d", k), cyc[k], cur[k].nbits * (cur[k].div + 1));
      end else begin
        chk($sformatf("spurious_done%0d", k), 1, 0);
      end
      cyc[k] = 0;
      have[k] = 1'b0;
    end else if (!snd && cyc[k] != 0) begin
      // Frame aborted by reset: its expectation is dropped.
      cyc[k] = 0;
      have[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, sending8, txd8, done8);
    mon(1, sending5, txd5, done5);
  end

  task automatic send_one8(input logic [7:0] d, input logic [1:0] pm, input logic ts, input int div);
    int w = 0;
    @(negedge clk);
    while (!ready8 && w < 300) begin @(negedge clk); w++; end
    if (!ready8) begin
      chk("send8_ready_timeout", 0, 1);
    end else begin
      d8 = d; pm8 = pm; ts8 = ts; div8 = 16'(div); send8 = 1'b1;
      sb8.push_back(mk({1'b0, d}, 8, pm, ts, div));
      npush8++;
      @(posedge clk);
      #1 send8 = 1'b0;
    end
  endtask

  task automatic wait_idle8(input string tag);
    int w = 0;
    @(negedge clk);
    while (sending8 && w < 1000) begin @(negedge clk); w++; end
    if (sending8) chk(tag, 0, 1);
  endtask

  initial begin
    int   rdy_cnt, gap;
    logic gap_txd, flag;

    #1 rst_n = 1'b0;
    #3;
    chk("rst_txd", txd8, 1);
    chk("rst_sending", sending8, 0);
    chk("rst_ready", ready8, 0);
    chk("rst_done", done8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", ready8, 1);

    // basic, parity variants, two stop bits
    send_one8(8'h70, PAR_NONE, 1'b0, 3); wait_idle8("basic_timeout");
    send_one8(8'h70, PAR_EVEN, 1'b0, 3); wait_idle8("even_timeout");
    send_one8(8'h70, PAR_ODD,  1'b0, 3); wait_idle8("odd_timeout");
    send_one8(8'h70, PAR_EVEN, 1'b1, 3); wait_idle8("stop2_timeout");
    send_one8(8'hC3, 2'b11,    1'b0, 2); wait_idle8("mode3_timeout");

    // back-to-back with tx_send held high
    @(negedge clk);
    d8 = 8'h55; div8 = 0; pm8 = PAR_NONE; ts8 = 1'b0; send8 = 1'b1;
    sb8.push_back(mk(9'h055, 8, PAR_NONE, 1'b0, 0)); npush8++;
    @(posedge clk);
    #1 d8 = 8'hAA;
    sb8.push_back(mk(9'h0AA, 8, PAR_NONE, 1'b0, 0)); npush8++;
    rdy_cnt = 0; gap = -1; gap_txd = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (ready8) begin rdy_cnt++; gap = i; gap_txd = txd8; end
    end
    @(posedge clk);
    #1 send8 = 1'b0;
    for (int i = 12; i <= 20; i++) begin
      @(negedge clk);
      if (ready8) rdy_cnt++;
    end
    chk("b2b_gap_idx", gap, 11);
    chk("b2b_ready_cnt", rdy_cnt, 1);
    chk("b2b_gap_txd", gap_txd, 1);
    wait_idle8("b2b_timeout");

    // disabled: request held but never accepted
    en8 = 1'b0; send8 = 1'b1; flag = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (txd8 !== 1'b1 || ready8 !== 1'b0 || sending8 !== 1'b0) flag = 1'b1;
    end
    chk("disabled_idle", flag, 0);
    send8 = 1'b0; en8 = 1'b1;

    // drop enable mid-frame and disturb inputs; frame must be unaffected
    @(negedge clk);
    d8 = 8'h3C; div8 = 2; pm8 = PAR_EVEN; ts8 = 1'b0; send8 = 1'b1;
    sb8.push_back(mk(9'h03C, 8, PAR_EVEN, 1'b0, 2)); npush8++;
    @(posedge clk);
    #1 en8 = 1'b0; d8 = 8'hFF; div8 = 7; pm8 = PAR_ODD; ts8 = 1'b1;
    wait_idle8("endrop_timeout");
    flag = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (sending8 !== 1'b0 || txd8 !== 1'b1) flag = 1'b1;
    end
    chk("endrop_no_restart", flag, 0);
    send8 = 1'b0; en8 = 1'b1;

    // reset during DATA
    send_one8(8'hA5, PAR_NONE, 1'b0, 3);
    repeat (10) @(posedge clk);
    chk("pre_rst_sending", sending8, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_txd", txd8, 1);
    chk("midrst_sending", sending8, 0);
    chk("midrst_ready", ready8, 0);
    chk("midrst_done", done8, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_one8(8'h0F, PAR_NONE, 1'b0, 3); wait_idle8("postrst_timeout");

    // 5-bit instance, odd parity
    @(negedge clk);
    chk("ready5", ready5, 1);
    d5 = 5'h1F; pm5 = PAR_ODD; div5 = 1; ts5 = 1'b0; send5 = 1'b1;
    sb5.push_back(mk(9'h01F, 5, PAR_ODD, 1'b0, 1));
    @(posedge clk);
    #1 send5 = 1'b0;
    begin
      int w = 0;
      @(negedge clk);
      while (sending5 && w < 200) begin @(negedge clk); w++; end
      if (sending5) chk("dw5_timeout", 0, 1);
    end

    repeat (3) @(negedge clk);
    chk("sb8_empty", sb8.size(), 0);
    chk("sb5_empty", sb5.size(), 0);
    chk("done_count8", ndone8, npush8 - 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
